// File: rtl/seg_scan_decoder.sv
// Multiplexed 4-digit seven-segment scan decoder: synchronizes anode/segment
// lines, captures each stable period once, and tracks per-digit BCD, blank and blink.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLINK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode,
    input  logic [7:0] seven_segment,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] digit_valid,
    output logic [3:0] blank,
    output logic [3:0] blink,
    output logic       frame_valid,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] LP_STABLE  = STABLE_CYCLES[7:0];
    localparam logic [7:0] LP_TIMEOUT = BLINK_TIMEOUT[7:0];

    logic [3:0] r_an_s1, r_an_s2;
    logic [7:0] r_seg_s1, r_seg_s2;
    logic [7:0] r_run;
    logic       r_done;
    logic [3:0] r_val [4];
    logic [7:0] r_idle [4];
    logic [3:0] r_dv, r_blank, r_blink, r_prev_blank, r_seen;
    logic       r_fv, r_err;
    logic [7:0] r_err_cnt;

    logic       w_change, w_cap, w_cap_legal, w_an_idle, w_num_ok, w_is_blank, w_err_now;
    logic [3:0] w_sel, w_num, w_cap_mask;

    // Comparing the stage feeding s2 against s2 restarts the run on the same edge
    // that s2 takes the new value, giving capture-to-output latency of STABLE+2 edges.
    assign w_change = {r_an_s1, r_seg_s1} != {r_an_s2, r_seg_s2};
    assign w_cap    = (r_run == LP_STABLE) && !r_done;

    always_comb begin
        w_sel = 4'b0000;
        case (r_an_s2)
            4'b0111: w_sel = 4'b1000;
            4'b1011: w_sel = 4'b0100;
            4'b1101: w_sel = 4'b0010;
            4'b1110: w_sel = 4'b0001;
            default: w_sel = 4'b0000;
        endcase
    end

    always_comb begin
        w_num      = 4'd0;
        w_num_ok   = 1'b1;
        w_is_blank = 1'b0;
        case (r_seg_s2[6:0])
            7'h40: w_num = 4'd0;
            7'h79: w_num = 4'd1;
            7'h24: w_num = 4'd2;
            7'h30: w_num = 4'd3;
            7'h19: w_num = 4'd4;
            7'h12: w_num = 4'd5;
            7'h02: w_num = 4'd6;
            7'h78: w_num = 4'd7;
            7'h00: w_num = 4'd8;
            7'h10: w_num = 4'd9;
            7'h7F: begin
                w_num_ok   = 1'b0;
                w_is_blank = 1'b1;
            end
            default: w_num_ok = 1'b0;
        endcase
    end

    assign w_an_idle   = (r_an_s2 == 4'hF);
    assign w_cap_legal = w_cap && (w_sel != 4'b0000);
    assign w_cap_mask  = w_cap_legal ? w_sel : 4'b0000;
    assign w_err_now   = w_cap && !w_an_idle &&
                         ((w_sel == 4'b0000) || (!w_num_ok && !w_is_blank));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_s1      <= '0;
            r_an_s2      <= '0;
            r_seg_s1     <= '0;
            r_seg_s2     <= '0;
            r_run        <= '0;
            r_done       <= 1'b0;
            r_dv         <= '0;
            r_blank      <= '0;
            r_blink      <= '0;
            r_prev_blank <= '0;
            r_seen       <= '0;
            r_fv         <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_val[i]  <= '0;
                r_idle[i] <= '0;
            end
        end else begin
            r_an_s1  <= anode;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= seven_segment;
            r_seg_s2 <= r_seg_s1;

            if (w_change) begin
                r_run  <= 8'd1;
                r_done <= 1'b0;
            end else begin
                if (r_run < LP_STABLE)
                    r_run <= r_run + 8'd1;
                if (w_cap)
                    r_done <= 1'b1;
            end

            r_err <= w_err_now;
            if (w_err_now && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;

            // A capture coinciding with the frame pulse seeds the next frame's mask.
            if (r_seen == 4'hF) begin
                r_fv   <= 1'b1;
                r_seen <= w_cap_mask;
            end else begin
                r_fv   <= 1'b0;
                r_seen <= r_seen | w_cap_mask;
            end

            for (int unsigned i = 0; i < 4; i++) begin
                if (r_fv && (r_idle[i] != 8'hFF))
                    r_idle[i] <= r_idle[i] + 8'd1;
                if (r_idle[i] >= LP_TIMEOUT)
                    r_blink[i] <= 1'b0;
                if (w_cap_mask[i]) begin
                    if (w_num_ok) begin
                        r_val[i]   <= w_num;
                        r_dv[i]    <= 1'b1;
                        r_blank[i] <= 1'b0;
                    end else begin
                        r_dv[i]    <= 1'b0;
                        r_blank[i] <= w_is_blank;
                    end
                    r_prev_blank[i] <= w_is_blank;
                    if (w_is_blank != r_prev_blank[i]) begin
                        r_blink[i] <= 1'b1;
                        r_idle[i]  <= 8'd0;
                    end
                end
            end
        end
    end

    assign min_t       = r_val[3];
    assign min_o       = r_val[2];
    assign sec_t       = r_val[1];
    assign sec_o       = r_val[0];
    assign digit_valid = r_dv;
    assign blank       = r_blank;
    assign blink       = r_blink;
    assign frame_valid = r_fv;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder: expected output snapshots are
// queued when stimulus is driven and popped for comparison once the DUT settles.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] anode;
    logic [7:0] seven_segment;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic [3:0] digit_valid, blank, blink;
    logic       frame_valid, err;
    logic [7:0] err_cnt;

    seg_scan_decoder #(.STABLE_CYCLES(4), .BLINK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .anode(anode), .seven_segment(seven_segment),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .digit_valid(digit_valid), .blank(blank), .blink(blink),
        .frame_valid(frame_valid), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [35:0] val;
    } sb_t;

    sb_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  fv_cnt = 0;
    int  err_pulses = 0;
    int  base_fv, base_err;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (err === 1'b1) err_pulses++;
    end

    function automatic logic [35:0] obs_vec();
        return {min_t, min_o, sec_t, sec_o, digit_valid, blank, blink, err_cnt};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [35:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs_vec(), e.val);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        anode = an;
        seven_segment = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [7:0] mt_seg);
        drive(4'b0111, mt_seg, 8);
        drive(4'b1011, 8'hA4, 8);
        drive(4'b1101, 8'h99, 8);
        drive(4'b1110, 8'h90, 8);
    endtask

    initial begin
        rst = 1'b1;
        anode = 4'hF;
        seven_segment = 8'hFF;
        repeat (3) @(negedge clk);
        sb_push("reset_state", 36'h0);
        sb_check();
        chk("reset_pulses", {34'h0, frame_valid, err}, 36'h0);
        rst = 1'b0;
        drive(4'hF, 8'hFF, 6);

        // Full scan: 0,2,4,9
        base_fv = fv_cnt;
        sb_push("scan_frame", {4'h0, 4'h2, 4'h4, 4'h9, 4'b1111, 4'b0000, 4'b0000, 8'd0});
        scan_frame(8'hC0);
        drive(4'hF, 8'hFF, 10);
        sb_check();
        chk("scan_fv_count", 36'(fv_cnt - base_fv), 36'd1);

        // Too-short stable period: no capture
        base_fv = fv_cnt;
        sb_push("short_period", {4'h0, 4'h2, 4'h4, 4'h9, 4'b1111, 4'b0000, 4'b0000, 8'd0});
        drive(4'b1110, 8'hF9, 3);
        drive(4'hF, 8'hFF, 10);
        sb_check();
        chk("short_fv_count", 36'(fv_cnt - base_fv), 36'd0);

        // Blink: min_t alternates blank/lit across frames
        base_fv = fv_cnt;
        sb_push("blink_set", {4'h0, 4'h2, 4'h4, 4'h9, 4'b0111, 4'b1000, 4'b1000, 8'd0});
        scan_frame(8'hFF);
        scan_frame(8'hC0);
        scan_frame(8'hFF);
        scan_frame(8'hC0);
        scan_frame(8'hFF);
        sb_check();
        sb_push("blink_hold7", {4'h0, 4'h2, 4'h4, 4'h9, 4'b1111, 4'b0000, 4'b1000, 8'd0});
        repeat (7) scan_frame(8'hC0);
        sb_check();
        sb_push("blink_timeout", {4'h0, 4'h2, 4'h4, 4'h9, 4'b1111, 4'b0000, 4'b0000, 8'd0});
        scan_frame(8'hC0);
        drive(4'hF, 8'hFF, 10);
        sb_check();
        chk("blink_fv_count", 36'(fv_cnt - base_fv), 36'd13);

        // Illegal anode, then illegal segment code at sec_o
        base_fv = fv_cnt;
        base_err = err_pulses;
        sb_push("errors", {4'h0, 4'h2, 4'h4, 4'h9, 4'b1110, 4'b0000, 4'b0000, 8'd2});
        drive(4'b0011, 8'hC0, 8);
        drive(4'b1110, 8'hAA, 8);
        drive(4'hF, 8'hFF, 10);
        sb_check();
        chk("err_pulse_count", 36'(err_pulses - base_err), 36'd2);
        chk("err_fv_count", 36'(fv_cnt - base_fv), 36'd0);

        // Reset mid-period, then full new period before capture
        drive(4'b1110, 8'hA4, 3);
        #2 rst = 1'b1;
        #1;
        sb_push("async_reset", 36'h0);
        sb_check();
        chk("async_reset_pulses", {34'h0, frame_valid, err}, 36'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_push("post_reset_edge5", 36'h0);
        repeat (5) @(negedge clk);
        sb_check();
        sb_push("post_reset_edge6", {4'h0, 4'h0, 4'h0, 4'h2, 4'b0001, 4'b0000, 4'b0000, 8'd0});
        @(negedge clk);
        sb_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
